// File: rtl/stdio_pkg.sv
// Shared types and character helpers for the stdout path: hex digit encoding,
// line terminators and the byte-serializer state encoding.
package stdio_pkg;

    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam logic [2:0] LAST_CHAR = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    function automatic logic [7:0] nibble_to_ascii(logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Indices 0..3 are the nibbles MSB first, then CR, then LF.
    function automatic logic [7:0] char_at(logic [15:0] word, logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = nibble_to_ascii(word[15:12]);
            3'd1:    c = nibble_to_ascii(word[11:8]);
            3'd2:    c = nibble_to_ascii(word[7:4]);
            3'd3:    c = nibble_to_ascii(word[3:0]);
            3'd4:    c = CHAR_CR;
            default: c = CHAR_LF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stdio_if.sv
// 16-bit valid/ready word channel between the stdout FIFO and its consumer.
interface stdio;
    logic        val;
    logic        rdy;
    logic [15:0] data;

    modport in     (input val, input data, output rdy);
    modport stdout (output val, output data, input rdy);
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer with a registered line output. A byte offered in the
// last STOP cycle starts immediately, so characters run back to back.
//
//   state | meaning
//   IDLE  | line high, ready for a byte
//   START | start bit (low) for CLKS_PER_BIT cycles
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); accepts the next byte on its last cycle
module uart_byte_tx
    import stdio_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] data,
    input  logic       val,
    output logic       rdy,
    output logic       tx_o
);

    localparam int unsigned    CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (baud_q == LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        case (state_q)
            IDLE: begin
                if (val) begin
                    state_d = START;
                    baud_d  = '0;
                    byte_d  = data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (val) begin
                        state_d = START;
                        byte_d  = data;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is computed from the next state so tx_o comes straight off a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = byte_d[bit_d];
            default: tx_d = 1'b1;
        endcase
        rdy = (state_q == IDLE) || ((state_q == STOP) && bit_end);
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/stdout_uart_tx.sv
// Renders each 16-bit stdout word as four hex digits plus CR LF on a UART line.
// One word in flight at a time; the next word is accepted one idle cycle after the last stop bit.
module stdout_uart_tx
    import stdio_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk_i,
    input  logic rst_ni,
    stdio.in     stdin,
    output logic tx_o,
    output logic busy_o
);

    if (CLKS_PER_BIT < 2) begin : g_param_check
        $error("stdout_uart_tx: CLKS_PER_BIT must be at least 2");
    end

    logic        active_q;
    logic [15:0] word_q;
    logic [2:0]  idx_q;
    logic        accept;
    logic        byte_val;
    logic        byte_rdy;
    logic [7:0]  byte_char;

    assign stdin.rdy = rst_ni && !active_q;
    assign accept    = stdin.val && stdin.rdy;

    // Character 0 comes straight from the bus so its start bit begins the cycle after accept.
    always_comb begin
        byte_val  = accept;
        byte_char = char_at(stdin.data, 3'd0);
        if (active_q) begin
            byte_val  = (idx_q != LAST_CHAR);
            byte_char = char_at(word_q, idx_q + 3'd1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            word_q   <= '0;
            idx_q    <= '0;
        end else if (accept) begin
            active_q <= 1'b1;
            word_q   <= stdin.data;
            idx_q    <= '0;
        end else if (active_q && byte_rdy) begin
            if (byte_val) begin
                idx_q <= idx_q + 3'd1;
            end else begin
                active_q <= 1'b0;
            end
        end
    end

    assign busy_o = active_q;

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .data   (byte_char),
        .val    (byte_val),
        .rdy    (byte_rdy),
        .tx_o   (tx_o)
    );

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Bench for stdout_uart_tx: words are pushed as expected ASCII bytes on accept
// and a bit-centre UART decoder pops and compares them.
module tb_stdout_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 60 * CPB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx;
    logic busy;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int rst_seen  = 0;
    int rx_count  = 0;
    logic [7:0] exp_q[$];

    stdio bus ();

    stdout_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .stdin  (bus),
        .tx_o   (tx),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) rst_seen <= rst_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
    endfunction

    task automatic push_word(input logic [15:0] w);
        exp_q.push_back(hex_char(w[15:12]));
        exp_q.push_back(hex_char(w[11:8]));
        exp_q.push_back(hex_char(w[7:4]));
        exp_q.push_back(hex_char(w[3:0]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Called on a falling edge; returns after the accepting rising edge.
    task automatic accept_word(input logic [15:0] w, output int acc);
        int n = 0;
        bus.val  = 1'b1;
        bus.data = w;
        while (bus.rdy !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("accept_timeout", 32'(n), 32'd0);
        push_word(w);
        acc = cyc;
        @(posedge clk);
    endtask

    // mode 0: val dropped; 1: val high with data churning; 2: val held, next word staged
    task automatic run_frame(input int mode, input logic [15:0] next_w);
        int   busy_cnt = 0;
        int   rdy_cnt  = 0;
        logic tx1 = 1'b1;
        logic busy_last = 1'b1;
        logic rdy_last = 1'b0;
        logic tx_last = 1'b0;
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (k <= FRAME && bus.rdy !== 1'b0) rdy_cnt++;
            if (k == 1) tx1 = tx;
            if (k == FRAME + 1) begin
                busy_last = busy;
                rdy_last  = bus.rdy;
                tx_last   = tx;
            end
            case (mode)
                0: bus.val = 1'b0;
                1: begin
                    bus.data = 16'($urandom);
                    bus.val  = (k < FRAME);
                end
                2: if (k == 1) bus.data = next_w;
                default: bus.val = 1'b0;
            endcase
        end
        chk("busy_cycles", 32'(busy_cnt), 32'(FRAME));
        chk("rdy_in_frame", 32'(rdy_cnt), 32'd0);
        chk("tx_first_start", 32'(tx1), 32'd0);
        chk("busy_after_frame", 32'(busy_last), 32'd0);
        chk("rdy_after_frame", 32'(rdy_last), 32'd1);
        chk("tx_idle_gap", 32'(tx_last), 32'd1);
    endtask

    initial begin : monitor
        logic [7:0] b;
        logic       start_bit;
        logic       stop_bit;
        int         rs;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                rs = rst_seen;
                repeat (CPB / 2) @(negedge clk);
                start_bit = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                stop_bit = tx;
                if (rs == rst_seen) begin
                    rx_count++;
                    chk("rx_start_bit", 32'(start_bit), 32'd0);
                    chk("rx_stop_bit", 32'(stop_bit), 32'd1);
                    if (exp_q.size() == 0) chk("rx_extra_byte", {24'h0, b}, 32'hFFFF_FFFF);
                    else chk("rx_byte", {24'h0, b}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin : watchdog
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: bench did not complete within 30000 cycles");
        $fatal(1);
    end

    initial begin : main
        int a1;
        int a2;
        int bad;
        bus.val  = 1'b0;
        bus.data = 16'h0000;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rdy", 32'(bus.rdy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_reset", 32'(bus.rdy), 32'd1);

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || bus.rdy !== 1'b1) bad++;
        end
        chk("idle_stable", 32'(bad), 32'd0);

        accept_word(16'h1A2F, a1); run_frame(0, 16'h0);
        accept_word(16'h0000, a1); run_frame(0, 16'h0);
        accept_word(16'hFFFF, a1); run_frame(0, 16'h0);
        accept_word(16'h9A00, a1); run_frame(0, 16'h0);

        accept_word(16'h1234, a1);
        run_frame(2, 16'hBEEF);
        accept_word(16'hBEEF, a2);
        chk("b2b_accept_gap", 32'(a2 - a1), 32'd241);
        run_frame(0, 16'h0);

        accept_word(16'hC3D7, a1);
        run_frame(1, 16'h0);

        // abort during bit 3 of character 2 (cycles 97..100 after accept)
        accept_word(16'h5A5A, a1);
        repeat (98) @(negedge clk);
        bus.val = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_rdy", 32'(bus.rdy), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_abort", 32'(bus.rdy), 32'd1);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("no_resume", 32'(bad), 32'd0);
        exp_q.delete();

        accept_word(16'h00A5, a1); run_frame(0, 16'h0);

        chk("rx_count", 32'(rx_count), 32'd50);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stdout_uart_tx.md
# stdout_uart_tx

Downstream consumer of the stdout FIFO. Accepts 16-bit TOY output words over the `stdio` valid/ready handshake and renders each word as four uppercase ASCII hex digits followed by CR LF. The characters are serialized 8N1 on a single UART transmit pin. It is the last stage between the TOY core's stdout path and the host terminal.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more; smaller values are an elaboration error.
- `clk_i  in  1`: the only clock; all state is updated on its rising edge.
- `rst_ni  in  1`: reset, synchronous, active-low.
- `stdin  in  stdio.in (val 1, rdy 1, data 16)`: word input, connected to the FIFO's `stdout` modport.
- `tx_o  out  1`: UART transmit line; idles high.
- `busy_o  out  1`: high whenever a word is being transmitted.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE
  - `stdin.rdy` = 1, `tx_o` = 1, `busy_o` = 0.
  - On `stdin.val && stdin.rdy`: capture `stdin.data` into the word register, clear the character index to 0, go to START.
  - `stdin.data` is sampled only on the accept cycle.
- Character `c` for index 0..5:
  - Indices 0..3 are nibbles [15:12], [11:8], [7:4], [3:0], so the most-significant nibble goes first.
  - Nibble n maps to 0x30+n for 0..9 and 0x41+(n−10) for 10..15.
  - Index 4 is 0x0D (CR); index 5 is 0x0A (LF).
- START: `tx_o` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with the bit index at 0.
- DATA: `tx_o` = `c[bit]`, sent LSB first. Each bit is held `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
- STOP: `tx_o` = 1 for `CLKS_PER_BIT` cycles. Then:
  - if the character index is below 5, increment it and go to START;
  - otherwise go to IDLE.
- `stdin.rdy` = 0 in START, DATA and STOP. There is no overlap between words and no skid buffer.
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`−1 and reloads to 0 on every bit boundary. Character index is 3 bits; bit index is 3 bits.

## Timing
- Reset state: while `rst_ni` = 0 at a clock edge, the FSM goes to IDLE and all counters go to 0.
- Reset output values:
  - `tx_o` = 1 and `busy_o` = 0.
  - `stdin.rdy` is forced to 0 combinationally while `rst_ni` is low.
  - `stdin.rdy` becomes 1 in the first cycle with `rst_ni` high.
- Accept timing: the word is accepted in cycle 0. The start bit of character 0 drives `tx_o` from cycle 1.
- Line activity per word is exactly 60·`CLKS_PER_BIT` cycles: 6 characters × 10 bits.
- The FSM is back in IDLE at cycle 60·`CLKS_PER_BIT`+1. A pending word can be accepted in that cycle, so there is exactly one idle-high cycle between back-to-back words.
- Reset mid-frame aborts the frame:
  - `tx_o` returns high on the next edge;
  - the partial word is discarded and never resumed;
  - the upstream word is not consumed again.
- Outputs `tx_o` and `busy_o` are registered, with no combinational path from `stdin.val` to `tx_o`. `stdin.rdy` is decoded from state.

## Structure
- Shared package `stdio_pkg` holds:
  - `CHAR_CR` (8'h0D) and `CHAR_LF` (8'h0A);
  - `function automatic logic [7:0] nibble_to_ascii(logic [3:0])`;
  - the state enum `tx_state_e`.
- One sub-module, `uart_byte_tx`:
  - it contains the START/DATA/STOP FSM and the baud counter;
  - its interface is a byte plus a valid/ready handshake, with a `tx_o` output.
- The top level sequences the 6 characters and owns the `stdio` handshake.

## Test plan
- `CLKS_PER_BIT`=4, word 0x1A2F → bytes 0x31, 0x41, 0x32, 0x46, 0x0D, 0x0A, decoded at bit centres. `busy_o` high for cycles 1..240.
- Word 0x0000 → 0x30 ×4, 0x0D, 0x0A. Word 0xFFFF → 0x46 ×4, 0x0D, 0x0A. Word 0x9A00 checks the 9/A boundary: 0x39, 0x41, 0x30, 0x30.
- Back-to-back: `val` held with 0x1234 then 0xBEEF (`CLKS_PER_BIT`=4) → second accept exactly 241 cycles after the first. `tx_o`=1 in that cycle; 12 characters total.
- Backpressure: `val`=1 with data changing every cycle during transmission → only the value present in the accept cycle is emitted. `rdy`=0 throughout the frame.
- Reset during bit 3 of character 2 → `tx_o`=1 on the next edge, `rdy`=0 while in reset, `rdy`=1 afterwards. A fresh word 0x00A5 is then sent completely and correctly.
- Post-reset idle: no `val` for 1000 cycles → `tx_o` constantly 1, `busy_o` 0, `rdy` 1.
